// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, drives the combinational instruction-memory read
// address and captures the returned word into the IF/ID register.
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IMEM_WORDS = 64
) (
    input  logic        i_clk,
    input  logic        i_reset,
    output logic [31:0] o_imem_addr,
    input  logic [31:0] i_imem_rdata,
    input  logic        i_stall,
    input  logic        i_redirect_valid,
    input  logic [31:0] i_redirect_target,
    output logic        o_if_id_valid,
    output logic [31:0] o_if_id_pc,
    output logic [31:0] o_if_id_pc_plus4,
    output logic [31:0] o_if_id_instr,
    output logic        o_fetch_fault,
    output logic [31:0] o_fault_addr,
    output logic [31:0] o_fetch_count
);

    localparam logic [31:0] IMEM_LIMIT = 32'(IMEM_WORDS) << 2;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        FAULT = 2'd2
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic        r_valid;
    logic [31:0] r_if_pc;
    logic [31:0] r_if_pc4;
    logic [31:0] r_if_instr;
    logic        r_fault;
    logic [31:0] r_fault_addr;
    logic [31:0] r_count;

    state_t      w_state_nxt;
    logic [31:0] w_pc_nxt;
    logic        w_valid_nxt;
    logic [31:0] w_if_pc_nxt;
    logic [31:0] w_if_pc4_nxt;
    logic [31:0] w_if_instr_nxt;
    logic        w_fault_nxt;
    logic [31:0] w_fault_addr_nxt;
    logic [31:0] w_count_nxt;

    logic [31:0] w_pc_plus4;
    logic        w_target_bad;

    assign w_pc_plus4   = r_pc + 32'd4;
    assign w_target_bad = (i_redirect_target[1:0] != 2'b00) ||
                          (i_redirect_target >= IMEM_LIMIT);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state      <= BOOT;
            r_pc         <= RESET_PC;
            r_valid      <= 1'b0;
            r_if_pc      <= 32'd0;
            r_if_pc4     <= 32'd0;
            r_if_instr   <= 32'd0;
            r_fault      <= 1'b0;
            r_fault_addr <= 32'd0;
            r_count      <= 32'd0;
        end else begin
            r_state      <= w_state_nxt;
            r_pc         <= w_pc_nxt;
            r_valid      <= w_valid_nxt;
            r_if_pc      <= w_if_pc_nxt;
            r_if_pc4     <= w_if_pc4_nxt;
            r_if_instr   <= w_if_instr_nxt;
            r_fault      <= w_fault_nxt;
            r_fault_addr <= w_fault_addr_nxt;
            r_count      <= w_count_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_pc_nxt         = r_pc;
        w_valid_nxt      = r_valid;
        w_if_pc_nxt      = r_if_pc;
        w_if_pc4_nxt     = r_if_pc4;
        w_if_instr_nxt   = r_if_instr;
        w_fault_nxt      = r_fault;
        w_fault_addr_nxt = r_fault_addr;
        w_count_nxt      = r_count;

        case (r_state)
            // One idle cycle while the instruction memory comes out of reset.
            BOOT: begin
                w_valid_nxt = 1'b0;
                w_state_nxt = RUN;
            end

            RUN: begin
                if (i_redirect_valid) begin
                    w_valid_nxt = 1'b0;
                    if (w_target_bad) begin
                        w_state_nxt      = FAULT;
                        w_fault_nxt      = 1'b1;
                        w_fault_addr_nxt = i_redirect_target;
                    end else begin
                        w_pc_nxt = i_redirect_target;
                    end
                end else if (!i_stall) begin
                    w_valid_nxt    = 1'b1;
                    w_if_pc_nxt    = r_pc;
                    w_if_pc4_nxt   = w_pc_plus4;
                    w_if_instr_nxt = i_imem_rdata;
                    w_count_nxt    = r_count + 32'd1;
                    // Last legal word is still delivered; fetch stops beyond it.
                    if (w_pc_plus4 >= IMEM_LIMIT) begin
                        w_state_nxt      = FAULT;
                        w_fault_nxt      = 1'b1;
                        w_fault_addr_nxt = w_pc_plus4;
                    end else begin
                        w_pc_nxt = w_pc_plus4;
                    end
                end
            end

            FAULT: begin
                w_valid_nxt = 1'b0;
            end

            default: begin
                w_state_nxt = BOOT;
                w_valid_nxt = 1'b0;
            end
        endcase
    end

    assign o_imem_addr      = r_pc;
    assign o_if_id_valid    = r_valid;
    assign o_if_id_pc       = r_if_pc;
    assign o_if_id_pc_plus4 = r_if_pc4;
    assign o_if_id_instr    = r_if_instr;
    assign o_fetch_fault    = r_fault;
    assign o_fault_addr     = r_fault_addr;
    assign o_fetch_count    = r_count;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for the fetch stage with a small combinational instruction
// memory model; expected values are hand-computed per step.
module tb_instruction_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        if_id_valid;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_pc_plus4;
    logic [31:0] if_id_instr;
    logic        fetch_fault;
    logic [31:0] fault_addr;
    logic [31:0] fetch_count;

    logic [31:0] mem [0:63];
    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    assign imem_rdata = mem[imem_addr[7:2]];

    instruction_fetch_unit #(.RESET_PC(32'h0), .IMEM_WORDS(64)) dut (
        .i_clk             (clk),
        .i_reset           (reset),
        .o_imem_addr       (imem_addr),
        .i_imem_rdata      (imem_rdata),
        .i_stall           (stall),
        .i_redirect_valid  (redirect_valid),
        .i_redirect_target (redirect_target),
        .o_if_id_valid     (if_id_valid),
        .o_if_id_pc        (if_id_pc),
        .o_if_id_pc_plus4  (if_id_pc_plus4),
        .o_if_id_instr     (if_id_instr),
        .o_fetch_fault     (fetch_fault),
        .o_fault_addr      (fault_addr),
        .o_fetch_count     (fetch_count)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " valid"}, 32'(if_id_valid), 32'd0);
        chk({tag, " pc"},    imem_addr,       32'd0);
        chk({tag, " ifpc"},  if_id_pc,        32'd0);
        chk({tag, " ifpc4"}, if_id_pc_plus4,  32'd0);
        chk({tag, " instr"}, if_id_instr,     32'd0);
        chk({tag, " fault"}, 32'(fetch_fault), 32'd0);
        chk({tag, " faddr"}, fault_addr,      32'd0);
        chk({tag, " count"}, fetch_count,     32'd0);
    endtask

    task automatic chk_cap(input string tag, input logic [31:0] pc, input logic [31:0] ins,
                           input logic [31:0] cnt);
        chk({tag, " valid"}, 32'(if_id_valid), 32'd1);
        chk({tag, " ifpc"},  if_id_pc,        pc);
        chk({tag, " ifpc4"}, if_id_pc_plus4,  pc + 32'd4);
        chk({tag, " instr"}, if_id_instr,     ins);
        chk({tag, " count"}, fetch_count,     cnt);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'hA500_0000 | 32'(i);
        mem[0] = 32'h00A08193;
        mem[1] = 32'h00408203;
        mem[2] = 32'h004182B3;
        mem[3] = 32'h404202B3;

        reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_target = 32'h0;
        step(); step();
        chk_zero("reset");
        reset = 1'b0;
        step();
        chk("boot valid", 32'(if_id_valid), 32'd0);
        chk("boot pc", imem_addr, 32'h0);
        step(); chk_cap("cap0", 32'h0, 32'h00A08193, 32'd1);
        chk("cap0 nextpc", imem_addr, 32'h4);
        step(); chk_cap("cap4", 32'h4, 32'h00408203, 32'd2);
        step(); chk_cap("cap8", 32'h8, 32'h004182B3, 32'd3);

        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_cap("stall", 32'h8, 32'h004182B3, 32'd3);
            chk("stall pc", imem_addr, 32'hC);
        end
        stall = 1'b0;
        step(); chk_cap("cap12", 32'hC, 32'h404202B3, 32'd4);
        chk("pc16", imem_addr, 32'h10);

        redirect_valid = 1'b1; redirect_target = 32'h40;
        step();
        chk("redir bubble", 32'(if_id_valid), 32'd0);
        chk("redir pc", imem_addr, 32'h40);
        chk("redir count", fetch_count, 32'd4);
        redirect_valid = 1'b0;
        step(); chk_cap("cap40", 32'h40, mem[16], 32'd5);

        stall = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h20;
        step();
        chk("redir+stall bubble", 32'(if_id_valid), 32'd0);
        chk("redir+stall pc", imem_addr, 32'h20);
        stall = 1'b0; redirect_valid = 1'b0;
        step(); chk_cap("cap20", 32'h20, mem[8], 32'd6);

        redirect_valid = 1'b1; redirect_target = 32'h42;
        step();
        chk("mis fault", 32'(fetch_fault), 32'd1);
        chk("mis faddr", fault_addr, 32'h42);
        chk("mis valid", 32'(if_id_valid), 32'd0);
        chk("mis pc", imem_addr, 32'h24);
        redirect_target = 32'h40; stall = 1'b1;
        step(); stall = 1'b0; step();
        chk("mis hold valid", 32'(if_id_valid), 32'd0);
        chk("mis hold pc", imem_addr, 32'h24);
        chk("mis hold faddr", fault_addr, 32'h42);
        chk("mis hold count", fetch_count, 32'd6);
        redirect_valid = 1'b0;

        reset = 1'b1;
        step();
        chk_zero("rst fault");
        reset = 1'b0;
        step(); chk("boot2 valid", 32'(if_id_valid), 32'd0);
        step(); chk_cap("boot2 cap", 32'h0, 32'h00A08193, 32'd1);

        redirect_valid = 1'b1; redirect_target = 32'h100;
        step();
        chk("oor fault", 32'(fetch_fault), 32'd1);
        chk("oor faddr", fault_addr, 32'h100);
        chk("oor valid", 32'(if_id_valid), 32'd0);
        redirect_target = 32'h8;
        step();
        chk("oor hold valid", 32'(if_id_valid), 32'd0);
        chk("oor hold pc", imem_addr, 32'h4);
        chk("oor hold faddr", fault_addr, 32'h100);
        redirect_valid = 1'b0;

        reset = 1'b1; step(); reset = 1'b0;
        step();
        redirect_valid = 1'b1; redirect_target = 32'hF8;
        step();
        chk("F8 pc", imem_addr, 32'hF8);
        redirect_valid = 1'b0;
        step(); chk_cap("capF8", 32'hF8, mem[62], 32'd1);
        chk("capF8 fault", 32'(fetch_fault), 32'd0);
        step(); chk_cap("capFC", 32'hFC, mem[63], 32'd2);
        chk("end fault", 32'(fetch_fault), 32'd1);
        chk("end faddr", fault_addr, 32'h100);
        chk("end pc", imem_addr, 32'hFC);
        stall = 1'b1;
        step();
        chk("end drop valid", 32'(if_id_valid), 32'd0);
        chk("end pc frozen", imem_addr, 32'hFC);
        chk("end count frozen", fetch_count, 32'd2);
        stall = 1'b0;

        reset = 1'b1; step(); reset = 1'b0;
        step(); step(); chk_cap("pre-stall cap", 32'h0, 32'h00A08193, 32'd1);
        stall = 1'b1;
        step();
        reset = 1'b1;
        step();
        chk_zero("rst stall");
        reset = 1'b0; stall = 1'b0;
        step(); chk("boot3 valid", 32'(if_id_valid), 32'd0);
        step(); chk_cap("boot3 cap", 32'h0, 32'h00A08193, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

endmodule
